// File: rtl/display_pkg.sv
// ============================================================================
// Module : display_pkg
// Brief  : Shared pattern codes, colour-bar table and sync idle-level helper
//          for the display test-pattern pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package display_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_HGRAD = 2'd2,
        PAT_VGRAD = 2'd3
    } pattern_t;

    // {r,g,b} per bar, bar 0 in the low bits: white, yellow, cyan, green,
    // magenta, red, blue, black.
    localparam logic [23:0] c_bar_table = {
        3'b000, 3'b001, 3'b100, 3'b101,
        3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return c_bar_table[int'(idx) * 3 +: 3];
    endfunction

    function automatic logic sync_idle(input logic pol);
        return ~pol;
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_sync_delay.sv
// ============================================================================
// Module : display_sync_delay
// Brief  : WIDTH-bit shift register of DEPTH stages, loaded with i_rst_val on
//          reset; DEPTH=0 degenerates to a wire.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module display_sync_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_pix_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = ^{1'b0, i_pix_clk, i_rst, i_rst_val};
            assign o_q      = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_pix_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= i_rst_val;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/display_pattern_gen.sv
// ============================================================================
// Module : display_pattern_gen
// Brief  : RGB test-pattern stage behind the timing generator; colour and
//          hs/vs/de leave exactly PIPE_STAGES cycles after entry.
//          Define DISPLAY_PATTERN_BORDER_EN to force a white 1-px frame border.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module display_pattern_gen
    import display_pkg::*;
#(
    parameter int COLOR_W     = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic               i_pix_clk,
    input  logic               i_rst,
    input  logic [11:0]        H_RES,
    input  logic [11:0]        V_RES,
    input  logic               H_POL,
    input  logic               V_POL,
    input  logic [1:0]         i_pattern_sel,
    input  logic [15:0]        i_sx,
    input  logic [15:0]        i_sy,
    input  logic               i_hs,
    input  logic               i_vs,
    input  logic               i_de,
    input  logic               i_frame,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_de,
    output logic [COLOR_W-1:0] o_r,
    output logic [COLOR_W-1:0] o_g,
    output logic [COLOR_W-1:0] o_b,
    output logic [15:0]        o_frame_count
);

    localparam int c_rgb_w = 3 * COLOR_W;

    pattern_t             r_pattern;
    logic [11:0]          r_h_res;
    logic [11:0]          r_v_res;
    logic [15:0]          r_frame_count;
    logic [11:0]          r_bar_pix;
    logic [2:0]           r_bar_idx;
    logic                 r_hs;
    logic                 r_vs;
    logic                 r_de;
    logic [c_rgb_w-1:0]   r_rgb;

    logic [11:0]          w_bar_w;
    logic [2:0]           w_bar_rgb;
    logic [4:0]           w_chk_sum;
    logic                 w_chk;
    logic [COLOR_W-1:0]   w_hgrad;
    logic [COLOR_W-1:0]   w_vgrad;
    logic [c_rgb_w-1:0]   w_rgb;
    logic [2:0]           w_sync_q;
    logic [c_rgb_w-1:0]   w_rgb_q;
    logic                 w_unused;

    // Pattern and resolution only change at the frame strobe.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_pattern     <= PAT_BARS;
            r_h_res       <= '0;
            r_v_res       <= '0;
            r_frame_count <= '0;
        end else if (i_frame) begin
            r_pattern     <= pattern_t'(i_pattern_sel);
            r_h_res       <= H_RES;
            r_v_res       <= V_RES;
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign w_bar_w = (r_h_res[11:3] == 9'd0) ? 12'd1 : {3'd0, r_h_res[11:3]};

    // Last bar saturates so it soaks up the H_RES % 8 remainder.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst || !i_de) begin
            r_bar_pix <= '0;
            r_bar_idx <= '0;
        end else if ((r_bar_pix == w_bar_w - 12'd1) && (r_bar_idx != 3'd7)) begin
            r_bar_pix <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_pix <= r_bar_pix + 12'd1;
        end
    end

    assign w_bar_rgb = bar_rgb(r_bar_idx);
    assign w_chk_sum = i_sx[4:0] + r_frame_count[4:0];
    assign w_chk     = w_chk_sum[4] ^ i_sy[4];
    assign w_hgrad   = i_sx[COLOR_W+2:3];
    assign w_vgrad   = i_sy[COLOR_W+2:3];

`ifdef DISPLAY_PATTERN_BORDER_EN
    logic [15:0] w_h_last;
    logic [15:0] w_v_last;
    logic        w_border;

    assign w_h_last = {4'd0, r_h_res} - 16'd1;
    assign w_v_last = {4'd0, r_v_res} - 16'd1;
    assign w_border = (i_sx == 16'd0) || (i_sx == w_h_last) ||
                      (i_sy == 16'd0) || (i_sy == w_v_last);
`endif

    always_comb begin
        w_rgb = '0;
        case (r_pattern)
            PAT_BARS:  w_rgb = {{COLOR_W{w_bar_rgb[2]}},
                                {COLOR_W{w_bar_rgb[1]}},
                                {COLOR_W{w_bar_rgb[0]}}};
            PAT_CHECK: w_rgb = {c_rgb_w{w_chk}};
            PAT_HGRAD: w_rgb = {3{w_hgrad}};
            PAT_VGRAD: w_rgb = {3{w_vgrad}};
        endcase
`ifdef DISPLAY_PATTERN_BORDER_EN
        if (w_border) begin
            w_rgb = '1;
        end
`endif
        if (!i_de) begin
            w_rgb = '0;
        end
    end

    assign w_unused = ^{i_sx, i_sy, r_h_res, r_v_res, w_chk_sum};

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_hs  <= sync_idle(H_POL);
            r_vs  <= sync_idle(V_POL);
            r_de  <= 1'b0;
            r_rgb <= '0;
        end else begin
            r_hs  <= i_hs;
            r_vs  <= i_vs;
            r_de  <= i_de;
            r_rgb <= w_rgb;
        end
    end

    display_sync_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_STAGES - 1)
    ) u_sync_delay (
        .i_pix_clk (i_pix_clk),
        .i_rst     (i_rst),
        .i_rst_val ({sync_idle(H_POL), sync_idle(V_POL), 1'b0}),
        .i_d       ({r_hs, r_vs, r_de}),
        .o_q       (w_sync_q)
    );

    display_sync_delay #(
        .WIDTH (c_rgb_w),
        .DEPTH (PIPE_STAGES - 1)
    ) u_rgb_delay (
        .i_pix_clk (i_pix_clk),
        .i_rst     (i_rst),
        .i_rst_val ({c_rgb_w{1'b0}}),
        .i_d       (r_rgb),
        .o_q       (w_rgb_q)
    );

    assign {o_hs, o_vs, o_de} = w_sync_q;
    assign {o_r, o_g, o_b}    = w_rgb_q;
    assign o_frame_count      = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_display_pattern_gen.sv
// ============================================================================
// Module : tb_display_pattern_gen
// Brief  : Directed bench for display_pattern_gen (COLOR_W=4, PIPE_STAGES=2),
//          640-wide lines with 160 px blanking, negative sync polarity.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_display_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] h_res, v_res;
    logic        h_pol, v_pol;
    logic [1:0]  pat;
    logic [15:0] sx, sy;
    logic        hs, vs, de, frame;
    logic        o_hs, o_vs, o_de;
    logic [3:0]  o_r, o_g, o_b;
    logic [15:0] o_frame_count;

    always #5 clk = ~clk;

    display_pattern_gen #(
        .COLOR_W     (4),
        .PIPE_STAGES (2)
    ) dut (
        .i_pix_clk     (clk),
        .i_rst         (rst),
        .H_RES         (h_res),
        .V_RES         (v_res),
        .H_POL         (h_pol),
        .V_POL         (v_pol),
        .i_pattern_sel (pat),
        .i_sx          (sx),
        .i_sy          (sy),
        .i_hs          (hs),
        .i_vs          (vs),
        .i_de          (de),
        .i_frame       (frame),
        .o_hs          (o_hs),
        .o_vs          (o_vs),
        .o_de          (o_de),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_frame_count (o_frame_count)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    int line_w = 640;
    int lb [0:1023];
    bit prev_valid;
    bit prev_hs, prev_vs, prev_de;
    int prev_x;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One line: active pixels 0..line_w-1 first, then blanking sx=-160..-1.
    task automatic scan_line(input int y, input bit strobe);
        int sync_err;
        int blank_err;
        int x;
        sync_err  = 0;
        blank_err = 0;
        for (int i = 0; i < 1024; i++) lb[i] = -1;
        for (int k = 0; k < line_w + 160; k++) begin
            x     = (k < line_w) ? k : k - line_w - 160;
            sx    = 16'(x);
            sy    = 16'(y);
            hs    = !(x >= -144 && x < -48);
            vs    = !(y >= -35 && y < -33);
            de    = (x >= 0) && (y >= 0);
            frame = strobe && (x == -160);
            @(posedge clk);
            #1;
            if (prev_valid) begin
                if ({o_hs, o_vs, o_de} !== {prev_hs, prev_vs, prev_de}) sync_err++;
                if (!prev_de && ({o_r, o_g, o_b} !== 12'h000)) blank_err++;
                if (prev_de) lb[prev_x] = int'({o_r, o_g, o_b});
            end
            prev_valid = 1'b1;
            prev_hs    = hs;
            prev_vs    = vs;
            prev_de    = de;
            prev_x     = x;
        end
        frame = 1'b0;
        check($sformatf("sync_align_y%0d", y), sync_err, 0);
        check($sformatf("blank_rgb_y%0d", y), blank_err, 0);
    endtask

    task automatic frame_start();
        scan_line(-45, 1'b1);
        scan_line(-35, 1'b0);
    endtask

    initial begin
        int nblk;
        rst = 1'b1; h_res = 12'd640; v_res = 12'd480; h_pol = 1'b0; v_pol = 1'b0;
        pat = 2'd1; sx = 16'd3; sy = 16'd3; hs = 1'b0; vs = 1'b0; de = 1'b1; frame = 1'b1;
        prev_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_de", o_de, 0);
        check("rst_rgb", {o_r, o_g, o_b}, 12'h000);
        check("rst_hs", o_hs, 1);
        check("rst_vs", o_vs, 1);
        check("rst_frame_count", o_frame_count, 0);
        rst = 1'b0; frame = 1'b0; de = 1'b0;

        // Frame 1: colour bars; selector moves to 2 mid-frame.
        pat = 2'd0;
        frame_start();
        check("frame_count_f1", o_frame_count, 1);
        pat = 2'd2;
        scan_line(0, 1'b0);
        check("bar_sx0_white", lb[0], 12'hFFF);
        check("bar_sx79_white", lb[79], 12'hFFF);
        check("bar_sx80_yellow", lb[80], 12'hFF0);
        check("bar_sx159_yellow", lb[159], 12'hFF0);
        check("bar_sx160_cyan", lb[160], 12'h0FF);
        check("bar_sx400_red", lb[400], 12'hF00);
        check("bar_sx559_blue", lb[559], 12'h00F);
        check("bar_sx560_black", lb[560], 12'h000);
        check("bar_sx639_black", lb[639], 12'h000);
        check("midframe_hold_sx8", lb[8], 12'hFFF);

        // Frame 2: horizontal gradient now in effect.
        frame_start();
        scan_line(0, 1'b0);
        check("hgrad_sx0", lb[0], 12'h000);
        check("hgrad_sx8", lb[8], 12'h111);
        check("hgrad_sx16", lb[16], 12'h222);
        check("hgrad_sx127", lb[127], 12'hFFF);
        check("hgrad_sx128_wrap", lb[128], 12'h000);

        // Frame 3: bars at 644 wide; the last bar takes the 4 extra pixels.
        pat = 2'd0; h_res = 12'd644; line_w = 644;
        frame_start();
        scan_line(0, 1'b0);
        nblk = 0;
        for (int i = 0; i < 644; i++) if (lb[i] == 0) nblk++;
        check("bar7_width_644", nblk, 84);
        check("bar644_sx80_yellow", lb[80], 12'hFF0);
        check("bar644_sx559_blue", lb[559], 12'h00F);
        check("bar644_sx643_black", lb[643], 12'h000);

        // Frames 4 and 5: checkerboard, boundary moves left with frame count.
        pat = 2'd1; h_res = 12'd640; line_w = 640;
        frame_start();
        check("frame_count_f4", o_frame_count, 4);
        scan_line(0, 1'b0);
        check("chk_f4_x11_y0", lb[11], 12'h000);
        check("chk_f4_x12_y0", lb[12], 12'hFFF);
        check("chk_f4_x16_y0", lb[16], 12'hFFF);
        check("chk_f4_x28_y0", lb[28], 12'h000);
        scan_line(16, 1'b0);
        check("chk_f4_x11_y16", lb[11], 12'hFFF);
        check("chk_f4_x12_y16", lb[12], 12'h000);
        frame_start();
        scan_line(0, 1'b0);
        check("chk_f5_x10_y0", lb[10], 12'h000);
        check("chk_f5_x11_y0", lb[11], 12'hFFF);

        // Frame 6: vertical gradient, border edges probed.
        pat = 2'd3;
        frame_start();
        check("frame_count_f6", o_frame_count, 6);
        scan_line(0, 1'b0);
`ifdef DISPLAY_PATTERN_BORDER_EN
        check("vg_x5_y0", lb[5], 12'hFFF);
`else
        check("vg_x5_y0", lb[5], 12'h000);
`endif
        scan_line(1, 1'b0);
        check("vg_x1_y1", lb[1], 12'h000);
        scan_line(5, 1'b0);
`ifdef DISPLAY_PATTERN_BORDER_EN
        check("vg_x0_y5", lb[0], 12'hFFF);
        check("vg_x639_y5", lb[639], 12'hFFF);
`else
        check("vg_x0_y5", lb[0], 12'h000);
        check("vg_x639_y5", lb[639], 12'h000);
`endif
        check("vg_x6_y5", lb[6], 12'h000);
        scan_line(100, 1'b0);
        check("vg_x5_y100", lb[5], 12'hCCC);
        scan_line(479, 1'b0);
`ifdef DISPLAY_PATTERN_BORDER_EN
        check("vg_x5_y479", lb[5], 12'hFFF);
`else
        check("vg_x5_y479", lb[5], 12'hBBB);
`endif

        // Reset in the middle of an active line.
        sx = 16'd5; sy = 16'd5; hs = 1'b1; vs = 1'b1; de = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_de", o_de, 0);
        check("midrst_rgb", {o_r, o_g, o_b}, 12'h000);
        check("midrst_hs", o_hs, 1);
        check("midrst_frame_count", o_frame_count, 0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

`default_nettype wire
